// File: rtl/bitplane_ram_xfer.sv
// Dual-port bit-plane RAM (LANES x DEPTH, column access) with a bit-serial
// host<->lane word transfer engine that borrows port B while busy.
module bitplane_ram_xfer #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LANE_W = 4,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [LANES-1:0]  dia,
    input  logic [LANES-1:0]  mska,
    output logic [LANES-1:0]  doa,
    input  logic              web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [LANES-1:0]  dib,
    input  logic [LANES-1:0]  mskb,
    output logic [LANES-1:0]  dob,
    input  logic              xfer_valid,
    output logic              xfer_ready,
    input  logic              xfer_write,
    input  logic [LANE_W-1:0] xfer_lane,
    input  logic [ADDR_W-1:0] xfer_base,
    input  logic [WORD_W-1:0] xfer_wdata,
    output logic [WORD_W-1:0] xfer_rdata,
    output logic              xfer_done,
    output logic              xfer_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_STORE, S_FETCH, S_DONE} state_t;

    logic [LANES-1:0]  mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              bad_q, bad_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [LANES-1:0]  doa_q, doa_d;
    logic [LANES-1:0]  dob_q, dob_d;

    logic              b_we_c;
    logic [ADDR_W-1:0] b_addr_c;
    logic [LANES-1:0]  b_di_c, b_msk_c, lane_msk_c;
    logic              a_ok_c, b_ok_c, lane_bit_c;
    logic [ADDR_W-1:0] addr_nxt_c;

    // Port B is owned by the engine for the whole transfer, including DONE
    always_comb begin
        lane_msk_c = LANES'(1) << lane_q;
        lane_bit_c = |(dob_q & lane_msk_c);
        addr_nxt_c = (32'(addr_q) == DEPTH - 1) ? '0 : addr_q + ADDR_W'(1);
        if (busy_q) begin
            b_we_c   = (state_q == S_STORE);
            b_addr_c = addr_q;
            b_di_c   = {LANES{wdata_q[0]}};
            b_msk_c  = lane_msk_c;
        end else begin
            b_we_c   = web;
            b_addr_c = addrb;
            b_di_c   = dib;
            b_msk_c  = mskb;
        end
        a_ok_c = 32'(addra) < DEPTH;
        b_ok_c = 32'(b_addr_c) < DEPTH;
        doa_d  = a_ok_c ? mem_q[addra] : '0;
        dob_d  = b_ok_c ? mem_q[b_addr_c] : '0;
    end

    // B is written before A so that A's lanes win on a same-address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                if (b_we_c && b_ok_c && b_msk_c[i]) mem_q[b_addr_c][i] <= b_di_c[i];
            end
            for (int i = 0; i < LANES; i++) begin
                if (wea && a_ok_c && mska[i]) mem_q[addra][i] <= dia[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        bad_d   = bad_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        unique case (state_q)
            S_IDLE: begin
                if (xfer_valid) begin
                    state_d = xfer_write ? S_STORE : S_FETCH;
                    cnt_d   = '0;
                    addr_d  = ADDR_W'(32'(xfer_base) % DEPTH);
                    lane_d  = xfer_lane;
                    bad_d   = 32'(xfer_lane) >= LANES;
                    wdata_d = xfer_wdata;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            S_STORE: begin
                wdata_d = wdata_q >> 1;
                addr_d  = addr_nxt_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (32'(cnt_q) == WORD_W - 1) state_d = S_DONE;
            end
            S_FETCH: begin
                // read issued on cycle j is captured on cycle j+1; bits shift in from the top
                if (cnt_q != '0) rdata_d = {lane_bit_c, rdata_q[WORD_W-1:1]};
                if (32'(cnt_q) == WORD_W) begin
                    state_d = S_DONE;
                end else begin
                    addr_d = addr_nxt_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                err_d   = bad_q;
                if (bad_q) rdata_d = '0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            bad_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            doa_q   <= '0;
            dob_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            bad_q   <= bad_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            doa_q   <= doa_d;
            dob_q   <= dob_d;
        end
    end

    assign doa        = doa_q;
    assign dob        = dob_q;
    assign xfer_rdata = rdata_q;
    assign xfer_done  = done_q;
    assign xfer_err   = err_q;
    assign busy       = busy_q;
    assign xfer_ready = ready_q;

endmodule

// File: tb/tb_bitplane_ram_xfer.sv
// Randomized self-checking bench for bitplane_ram_xfer against an array-based reference model.
module tb_bitplane_ram_xfer;

    localparam int unsigned LANES  = 16;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LANE_W = 5;
    localparam int unsigned WORD_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              wea, web, xfer_valid, xfer_write;
    logic [ADDR_W-1:0] addra, addrb, xfer_base;
    logic [LANES-1:0]  dia, mska, dib, mskb, doa, dob;
    logic [LANE_W-1:0] xfer_lane;
    logic [WORD_W-1:0] xfer_wdata, xfer_rdata;
    logic              xfer_ready, xfer_done, xfer_err, busy;

    logic [LANES-1:0]  mdl [DEPTH];
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    bitplane_ram_xfer #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                        .LANE_W(LANE_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .reset(reset),
        .wea(wea), .addra(addra), .dia(dia), .mska(mska), .doa(doa),
        .web(web), .addrb(addrb), .dib(dib), .mskb(mskb), .dob(dob),
        .xfer_valid(xfer_valid), .xfer_ready(xfer_ready), .xfer_write(xfer_write),
        .xfer_lane(xfer_lane), .xfer_base(xfer_base), .xfer_wdata(xfer_wdata),
        .xfer_rdata(xfer_rdata), .xfer_done(xfer_done), .xfer_err(xfer_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One column cycle on both ports; expected reads are the model contents before the writes
    task automatic col_op(input logic wa, input logic [ADDR_W-1:0] aa, input logic [LANES-1:0] da,
                          input logic [LANES-1:0] ma, input logic wb, input logic [ADDR_W-1:0] ab,
                          input logic [LANES-1:0] db, input logic [LANES-1:0] mb, input bit do_chk);
        logic [LANES-1:0] ea, eb;
        ea = mdl[aa];
        eb = mdl[ab];
        wea = wa; addra = aa; dia = da; mska = ma;
        web = wb; addrb = ab; dib = db; mskb = mb;
        @(posedge clk); #1;
        if (do_chk) begin
            chk("doa", doa, ea);
            chk("dob", dob, eb);
        end
        wea = 1'b0; web = 1'b0;
        if (wb) mdl[ab] = (mdl[ab] & ~mb) | (db & mb);
        if (wa) mdl[aa] = (mdl[aa] & ~ma) | (da & ma);
    endtask

    // Full transfer; cj >= 0 makes port A overwrite lane 3 at the column the engine hits on step cj
    task automatic xfer(input bit wr, input int lane, input int base, input logic [WORD_W-1:0] wd,
                        input int cj);
        logic [WORD_W-1:0] exp_rd;
        bit                bad, done_seen;
        int                n, col;
        bad = (lane >= int'(LANES));
        exp_rd = '0;
        if (!wr && !bad)
            for (int j = 0; j < int'(WORD_W); j++) exp_rd[j] = mdl[(base + j) % DEPTH][lane];
        chk("ready_idle", xfer_ready, 1);
        xfer_valid = 1'b1; xfer_write = wr; xfer_lane = LANE_W'(lane);
        xfer_base = ADDR_W'(base); xfer_wdata = wd;
        @(posedge clk); #1;
        xfer_valid = 1'b0;
        chk("busy_accept", busy, 1);
        chk("ready_accept", xfer_ready, 0);
        n = 0;
        done_seen = 0;
        while (!done_seen && n < 60) begin
            col = (base + n) % DEPTH;
            web = 1'b1; addrb = ADDR_W'(col); dib = LANES'($urandom); mskb = '1;
            if (n == cj && cj < int'(WORD_W)) begin
                wea = 1'b1; addra = ADDR_W'(col); dia = {LANES{~wd[cj]}}; mska = LANES'(8);
            end
            @(posedge clk); #1;
            wea = 1'b0;
            n++;
            if (xfer_done) done_seen = 1;
        end
        web = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("latency", 64'(n), wr ? 64'd33 : 64'd34);
        chk("err", xfer_err, bad);
        chk("busy_done", busy, 0);
        chk("ready_done", xfer_ready, 1);
        if (!wr || bad) chk("rdata", xfer_rdata, exp_rd);
        if (wr && !bad)
            for (int j = 0; j < int'(WORD_W); j++) mdl[(base + j) % DEPTH][lane] = wd[j];
        if (cj >= 0 && cj < int'(WORD_W)) mdl[(base + cj) % DEPTH][3] = ~wd[cj];
        @(posedge clk); #1;
        chk("done_pulse", xfer_done, 0);
    endtask

    initial begin
        int pulses;
        logic [LANES-1:0] v;
        reset = 1'b0; wea = 0; web = 0; xfer_valid = 0; xfer_write = 0;
        addra = '0; addrb = '0; dia = '0; dib = '0; mska = '0; mskb = '0;
        xfer_lane = '0; xfer_base = '0; xfer_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_doa", doa, 0);
        chk("rst_dob", dob, 0);
        chk("rst_rdata", xfer_rdata, 0);
        chk("rst_done", xfer_done, 0);
        chk("rst_err", xfer_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", xfer_ready, 1);
        reset = 1'b1;

        for (int a = 0; a < int'(DEPTH) / 2; a++)
            col_op(1, ADDR_W'(a), LANES'($urandom), '1, 1, ADDR_W'(a + DEPTH / 2), LANES'($urandom), '1, 0);

        // random column traffic in a small window to provoke collisions
        for (int i = 0; i < 200; i++)
            col_op(1'($urandom), ADDR_W'($urandom_range(0, 15)), LANES'($urandom), LANES'($urandom),
                   1'($urandom), ADDR_W'($urandom_range(0, 15)), LANES'($urandom), LANES'($urandom), 1);

        col_op(1, 5, 16'hA5A5, 16'hFFFF, 0, 0, 0, 0, 1);
        col_op(0, 5, 0, 0, 0, 0, 0, 0, 1);
        chk("t1_read", doa, 16'hA5A5);

        col_op(1, 7, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 1);
        col_op(1, 7, 16'hFFFF, 16'h00F0, 0, 0, 0, 0, 1);
        chk("t2_readfirst", doa, 16'h0000);
        col_op(0, 7, 0, 0, 0, 0, 0, 0, 1);
        chk("t2_mask", doa, 16'h00F0);

        col_op(1, 9, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 1);
        col_op(1, 9, 16'hFFFF, 16'h00FF, 1, 9, 16'h0000, 16'h0FF0, 1);
        col_op(0, 9, 0, 0, 0, 9, 0, 0, 1);
        chk("t3_collide", doa, 16'hF0FF);

        xfer(1, 3, 1020, 32'hDEADBEEF, -1);
        xfer(0, 3, 1020, 32'h0, -1);
        chk("t4_word", xfer_rdata, 32'hDEADBEEF);
        for (int a = 1020; a < 1024; a++) col_op(0, ADDR_W'(a), 0, 0, 0, ADDR_W'((a + 4) % DEPTH), 0, 0, 1);
        for (int a = 4; a < 28; a++) col_op(0, ADDR_W'(a), 0, 0, 0, 0, 0, 0, 1);

        xfer(1, 20, 100, 32'h12345678, -1);
        chk("t5_bad_rdata", xfer_rdata, 0);

        // abort a fetch with reset; a write on port A during that edge must be dropped
        xfer_valid = 1'b1; xfer_write = 1'b0; xfer_lane = 5'd2; xfer_base = 10'd200;
        @(posedge clk); #1;
        xfer_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        v = mdl[50];
        wea = 1'b1; addra = 10'd50; dia = ~v; mska = '1;
        @(posedge clk); #1;
        wea = 1'b0; reset = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", xfer_ready, 1);
        chk("abort_done", xfer_done, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (xfer_done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 0);
        col_op(0, 50, 0, 0, 0, 0, 0, 0, 1);
        xfer(0, 2, 200, 32'h0, -1);

        xfer(1, 3, 600, 32'hA5F00F5A, 7);
        xfer(0, 3, 600, 32'h0, -1);

        for (int i = 0; i < 12; i++) begin
            int ln, bs;
            logic [WORD_W-1:0] w;
            ln = $urandom_range(0, 17);
            bs = $urandom_range(0, DEPTH - 1);
            w  = $urandom;
            xfer(1, ln, bs, w, -1);
            xfer(0, ln, bs, 32'h0, -1);
            xfer(0, $urandom_range(0, 17), $urandom_range(0, DEPTH - 1), 32'h0, -1);
        end

        for (int a = 0; a < int'(DEPTH) / 2; a++)
            col_op(0, ADDR_W'(a), 0, 0, 0, ADDR_W'(a + DEPTH / 2), 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
